// File: rtl/fsb8_arb.sv
// fsb8_arb: two-master arbiter (m0 = core load/store, m1 = DMA) in front of the FSB8 bridge slave port.
// Optional bridge-stall timeout is compiled in when FSB8_ARB_TIMEOUT_EN is defined.
module fsb8_arb #(
  parameter int ADDR_WIDTH     = 24,
  parameter int MAX_BURST      = 256,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  // master 0: core
  input  logic                  m0_hsel,
  input  logic                  m0_hsel_cmd,
  input  logic                  m0_htrans,
  input  logic                  m0_hburst,
  input  logic                  m0_hwrite,
  input  logic [ADDR_WIDTH-1:0] m0_haddr,
  input  logic [7:0]            m0_hwdata,
  output logic [7:0]            m0_hrdata,
  output logic                  m0_hready,
  output logic                  m0_hresp,
  // master 1: DMA
  input  logic                  m1_hsel,
  input  logic                  m1_htrans,
  input  logic                  m1_hburst,
  input  logic                  m1_hwrite,
  input  logic [ADDR_WIDTH-1:0] m1_haddr,
  input  logic [7:0]            m1_hwdata,
  output logic [7:0]            m1_hrdata,
  output logic                  m1_hready,
  output logic                  m1_hresp,
  // bridge slave port
  output logic                  s_hsel,
  output logic                  s_hsel_cmd,
  output logic                  s_htrans,
  output logic                  s_hburst,
  output logic                  s_hwrite,
  output logic [ADDR_WIDTH-1:0] s_haddr,
  output logic [7:0]            s_hwdata,
  input  logic [7:0]            s_hrdata,
  input  logic                  s_hready,
  input  logic                  s_hresp,
  // status
  output logic [1:0]            gnt,
  output logic                  last_gnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_e;

  localparam logic [7:0] BEAT_CAP = 8'(MAX_BURST - 1);

  state_e                  state_q, state_d;
  logic                    last_gnt_q, last_gnt_d;
  logic [7:0]              beat_q, beat_d;

  logic                    req0, req1;
  logic                    own, own1;
  logic                    mx_hsel, mx_htrans, mx_hburst, mx_hwrite;
  logic [ADDR_WIDTH-1:0]   mx_haddr;
  logic [7:0]              mx_hwdata;
  logic                    burst_ok, beat_done, exit_grant, timeout;

  assign req0 = (m0_hsel | m0_hsel_cmd) & m0_htrans;
  assign req1 = m1_hsel & m1_htrans;
  assign own  = (state_q != ST_IDLE);
  assign own1 = (state_q == ST_OWN1);

  assign mx_hsel   = own1 ? m1_hsel   : m0_hsel;
  assign mx_htrans = own1 ? m1_htrans : m0_htrans;
  assign mx_hburst = own1 ? m1_hburst : m0_hburst;
  assign mx_hwrite = own1 ? m1_hwrite : m0_hwrite;
  assign mx_haddr  = own1 ? m1_haddr  : m0_haddr;
  assign mx_hwdata = own1 ? m1_hwdata : m0_hwdata;

  // Masking hburst on the last allowed beat makes the bridge close the burst, which releases the grant.
  assign burst_ok   = mx_hburst & (beat_q != BEAT_CAP);
  assign beat_done  = own & s_hready;
  assign exit_grant = beat_done & (~burst_ok | ~mx_htrans);

`ifdef FSB8_ARB_TIMEOUT_EN
  localparam int            SW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(TIMEOUT_CYCLES - 1);

  logic [SW-1:0] stall_q, stall_d;

  // stall_q holds the stalled cycles already elapsed, so the limit fires on the TIMEOUT_CYCLES-th one.
  assign timeout = own & ~s_hready & (stall_q == STALL_LIM);

  always_comb begin
    stall_d = stall_q + 1'b1;
    if (!own || s_hready || timeout) stall_d = '0;
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) stall_q <= '0;
    else           stall_q <= stall_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    beat_d     = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && (!req1 || last_gnt_q)) begin
          state_d    = ST_OWN0;
          last_gnt_d = 1'b0;
          beat_d     = '0;
        end else if (req1) begin
          state_d    = ST_OWN1;
          last_gnt_d = 1'b1;
          beat_d     = '0;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (beat_done && (beat_q != 8'hFF)) beat_d = beat_q + 8'd1;
        if (exit_grant || timeout) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b1;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      beat_q     <= beat_d;
    end
  end

  always_comb begin
    s_hsel     = 1'b0;
    s_hsel_cmd = 1'b0;
    s_htrans   = 1'b0;
    s_hburst   = 1'b0;
    s_hwrite   = 1'b0;
    s_haddr    = '0;
    s_hwdata   = '0;
    if (own) begin
      s_hsel     = mx_hsel & ~timeout;
      s_hsel_cmd = ~own1 & m0_hsel_cmd;
      s_htrans   = mx_htrans & ~timeout;
      s_hburst   = burst_ok;
      s_hwrite   = mx_hwrite;
      s_haddr    = mx_haddr;
      s_hwdata   = mx_hwdata;
    end
  end

  logic [1:0] rsp_ready, rsp_resp;
  logic [7:0] rsp_rdata [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic owner;
    assign owner          = (state_q == ((gi == 0) ? ST_OWN0 : ST_OWN1));
    assign gnt[gi]        = owner;
    assign rsp_ready[gi]  = owner & (s_hready | timeout);
    assign rsp_resp[gi]   = owner & (s_hresp | timeout);
    assign rsp_rdata[gi]  = owner ? s_hrdata : 8'h00;
  end

  assign m0_hready = rsp_ready[0];
  assign m0_hresp  = rsp_resp[0];
  assign m0_hrdata = rsp_rdata[0];
  assign m1_hready = rsp_ready[1];
  assign m1_hresp  = rsp_resp[1];
  assign m1_hrdata = rsp_rdata[1];
  assign last_gnt  = last_gnt_q;

endmodule

// File: tb/tb_fsb8_arb.sv
// Table-driven bench for fsb8_arb (MAX_BURST=4) with a scoreboard queue; extra timeout run under FSB8_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_fsb8_arb;
  localparam int AW = 24;
  localparam logic [AW-1:0] A0 = 24'h001234;
  localparam logic [AW-1:0] A1 = 24'h00ABCD;
  localparam logic [7:0]    D0 = 8'h12;
  localparam logic [7:0]    D1 = 8'h34;

  logic          hclk = 1'b0;
  logic          hreset_n;
  logic          m0_hsel, m0_hsel_cmd, m0_htrans, m0_hburst, m0_hwrite;
  logic [AW-1:0] m0_haddr;
  logic [7:0]    m0_hwdata, m0_hrdata;
  logic          m0_hready, m0_hresp;
  logic          m1_hsel, m1_htrans, m1_hburst, m1_hwrite;
  logic [AW-1:0] m1_haddr;
  logic [7:0]    m1_hwdata, m1_hrdata;
  logic          m1_hready, m1_hresp;
  logic          s_hsel, s_hsel_cmd, s_htrans, s_hburst, s_hwrite;
  logic [AW-1:0] s_haddr;
  logic [7:0]    s_hwdata, s_hrdata;
  logic          s_hready, s_hresp;
  logic [1:0]    gnt;
  logic          last_gnt;

  always #5 hclk = ~hclk;

  fsb8_arb #(.ADDR_WIDTH(AW), .MAX_BURST(4), .TIMEOUT_CYCLES(8)) dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .m0_hsel(m0_hsel), .m0_hsel_cmd(m0_hsel_cmd), .m0_htrans(m0_htrans), .m0_hburst(m0_hburst),
    .m0_hwrite(m0_hwrite), .m0_haddr(m0_haddr), .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata),
    .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_hsel(m1_hsel), .m1_htrans(m1_htrans), .m1_hburst(m1_hburst),
    .m1_hwrite(m1_hwrite), .m1_haddr(m1_haddr), .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata),
    .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_hsel(s_hsel), .s_hsel_cmd(s_hsel_cmd), .s_htrans(s_htrans), .s_hburst(s_hburst),
    .s_hwrite(s_hwrite), .s_haddr(s_haddr), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata),
    .s_hready(s_hready), .s_hresp(s_hresp), .gnt(gnt), .last_gnt(last_gnt)
  );

  typedef struct packed {
    logic       m0_sel, m0_cmd, m0_tr, m0_bu, m1_sel, m1_tr, m1_bu, rdy, resp;
    logic [7:0] rdata;
    logic [1:0] own;    // 0 idle, 1 master 0, 2 master 1
    logic       burst;  // expected s_hburst
    logic       lg;     // expected last_gnt
  } vec_t;

  typedef struct packed {
    logic [1:0]    gnt;
    logic          lg, sel, cmd, tr, bu, wr;
    logic [AW-1:0] addr;
    logic [7:0]    wd;
    logic          r0, e0;
    logic [7:0]    d0;
    logic          r1, e1;
    logic [7:0]    d1;
  } exp_t;

  exp_t  sb[$];
  vec_t  tbl[$];
  string tbl_tag[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic vec_t v(input int m0s, input int m0c, input int m0t, input int m0b,
                             input int m1s, input int m1t, input int m1b,
                             input int rdy, input int rsp, input int rd,
                             input int own, input int bu, input int lg);
    vec_t x;
    x.m0_sel = m0s[0]; x.m0_cmd = m0c[0]; x.m0_tr = m0t[0]; x.m0_bu = m0b[0];
    x.m1_sel = m1s[0]; x.m1_tr = m1t[0]; x.m1_bu = m1b[0];
    x.rdy = rdy[0]; x.resp = rsp[0]; x.rdata = rd[7:0];
    x.own = own[1:0]; x.burst = bu[0]; x.lg = lg[0];
    return x;
  endfunction

  // Owner's request is forwarded to the bridge and the bridge response returned to the owner only.
  function automatic exp_t expect_of(input vec_t x);
    exp_t e;
    e    = '0;
    e.lg = x.lg;
    e.bu = x.burst;
    if (x.own == 2'd1) begin
      e.gnt = 2'b01; e.sel = x.m0_sel; e.cmd = x.m0_cmd; e.tr = x.m0_tr; e.wr = 1'b0;
      e.addr = A0; e.wd = D0; e.r0 = x.rdy; e.e0 = x.resp; e.d0 = x.rdata;
    end else if (x.own == 2'd2) begin
      e.gnt = 2'b10; e.sel = x.m1_sel; e.cmd = 1'b0; e.tr = x.m1_tr; e.wr = 1'b1;
      e.addr = A1; e.wd = D1; e.r1 = x.rdy; e.e1 = x.resp; e.d1 = x.rdata;
    end
    return e;
  endfunction

  task automatic drive(input vec_t x);
    m0_hsel = x.m0_sel; m0_hsel_cmd = x.m0_cmd; m0_htrans = x.m0_tr; m0_hburst = x.m0_bu;
    m1_hsel = x.m1_sel; m1_htrans = x.m1_tr; m1_hburst = x.m1_bu;
    s_hready = x.rdy; s_hresp = x.resp; s_hrdata = x.rdata;
  endtask

  task automatic compare(input string tag);
    exp_t e, o;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, nothing expected", tag);
      return;
    end
    e = sb.pop_front();
    o.gnt = gnt; o.lg = last_gnt; o.sel = s_hsel; o.cmd = s_hsel_cmd; o.tr = s_htrans;
    o.bu = s_hburst; o.wr = s_hwrite; o.addr = s_haddr; o.wd = s_hwdata;
    o.r0 = m0_hready; o.e0 = m0_hresp; o.d0 = m0_hrdata;
    o.r1 = m1_hready; o.e1 = m1_hresp; o.d1 = m1_hrdata;
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL %s: got gnt=%b lg=%b sel=%b cmd=%b tr=%b bu=%b rdy0=%b rsp0=%b rd0=%h rdy1=%b rsp1=%b rd1=%h (all=%h) required gnt=%b lg=%b sel=%b cmd=%b tr=%b bu=%b rdy0=%b rsp0=%b rd0=%h rdy1=%b rsp1=%b rd1=%h (all=%h)",
               tag, o.gnt, o.lg, o.sel, o.cmd, o.tr, o.bu, o.r0, o.e0, o.d0, o.r1, o.e1, o.d1, o,
               e.gnt, e.lg, e.sel, e.cmd, e.tr, e.bu, e.r0, e.e0, e.d0, e.r1, e.e1, e.d1, e);
    end else begin
      $display("%s: ok gnt=%b last_gnt=%b s_hburst=%b m0_hready=%b m1_hready=%b", tag, o.gnt, o.lg, o.bu, o.r0, o.r1);
    end
  endtask

  task automatic apply_exp(input vec_t x, input exp_t e, input string tag);
    drive(x);
    sb.push_back(e);
    @(negedge hclk);
    compare(tag);
    @(posedge hclk);
    #1;
  endtask

  task automatic apply(input vec_t x, input string tag);
    apply_exp(x, expect_of(x), tag);
  endtask

  task automatic add(input vec_t x, input string tag);
    tbl.push_back(x);
    tbl_tag.push_back(tag);
  endtask

  initial begin
    vec_t  x;
    exp_t  e;
    bit    cap_bu[10] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 0};

    m0_haddr = A0; m0_hwdata = D0; m0_hwrite = 1'b0;
    m1_haddr = A1; m1_hwdata = D1; m1_hwrite = 1'b1;
    hreset_n = 1'b0;
    drive(v(0,0,0,0, 0,0,0, 0,0,0, 0,0,1));
    @(posedge hclk);
    #1;
    // reset held with both masters requesting: everything quiet, last_gnt=1
    apply(v(1,0,1,0, 1,1,0, 1,1,8'hEE, 0,0,1), "reset");
    hreset_n = 1'b1;

    // tie after reset, alternating for 4 grants
    for (int r = 0; r < 2; r++) begin
      add(v(1,0,1,0, 1,1,0, 1,0,8'h11, 0,0,1), "tie_idle_a");
      add(v(1,0,1,0, 1,1,0, 1,0,8'h11, 1,0,0), "tie_m0");
      add(v(1,0,1,0, 1,1,0, 1,0,8'h22, 0,0,0), "tie_idle_b");
      add(v(1,0,1,0, 1,1,0, 1,0,8'h22, 2,0,1), "tie_m1");
    end
    // single read, bridge waits 3 cycles then returns 0xA5
    add(v(1,0,1,0, 0,0,0, 0,0,0,     0,0,1), "rd_idle");
    for (int i = 0; i < 3; i++) add(v(1,0,1,0, 0,0,0, 0,0,0, 1,0,0), "rd_wait");
    add(v(1,0,1,0, 0,0,0, 1,0,8'hA5, 1,0,0), "rd_data");
    add(v(0,0,0,0, 0,0,0, 0,0,0,     0,0,0), "rd_after");
    // burst cap: m1 10-beat write, regranted after each 4 beats with one idle gap
    add(v(0,0,0,0, 1,1,1, 1,0,0, 0,0,0), "cap_idle");
    for (int b = 1; b <= 10; b++) begin
      if (b == 5 || b == 9) add(v(0,0,0,0, 1,1,1, 1,0,0, 0,0,1), "cap_gap");
      add(v(0,0,0,0, 1,1,(b != 10), 1,0,b, 2,cap_bu[b-1],1), $sformatf("cap_beat%0d", b));
    end
    add(v(0,0,0,0, 0,0,0, 0,0,0, 0,0,1), "cap_done");
    // preemption: m0 requests during m1 beat 2 and wins after m1 beat 4
    add(v(0,0,0,0, 1,1,1, 1,0,0, 0,0,1), "pre_idle");
    add(v(0,0,0,0, 1,1,1, 1,0,1, 2,1,1), "pre_b1");
    add(v(1,0,1,0, 1,1,1, 1,0,2, 2,1,1), "pre_b2");
    add(v(1,0,1,0, 1,1,1, 1,0,3, 2,1,1), "pre_b3");
    add(v(1,0,1,0, 1,1,1, 1,0,4, 2,0,1), "pre_b4");
    add(v(1,0,1,0, 1,1,1, 1,0,0, 0,0,1), "pre_gap");
    add(v(1,0,1,0, 1,1,1, 1,0,8'h66, 1,0,0), "pre_m0");
    add(v(0,0,0,0, 1,1,0, 1,0,0, 0,0,0), "pre_gap2");
    add(v(0,0,0,0, 1,1,0, 1,0,8'h77, 2,0,1), "pre_m1");
    add(v(0,0,0,0, 0,0,0, 0,0,0, 0,0,1), "pre_done");
    // command cycle on m0; m1 owning with m0_hsel_cmd high must not leak it
    add(v(0,1,1,0, 0,0,0, 1,0,0,     0,0,1), "cmd_idle");
    add(v(0,1,1,0, 0,0,0, 1,0,8'h5A, 1,0,0), "cmd_m0");
    add(v(0,1,0,0, 1,1,0, 1,0,0,     0,0,0), "cmd_idle2");
    add(v(0,1,0,0, 1,1,0, 1,0,8'h3C, 2,0,1), "cmd_m1");
    add(v(0,0,0,0, 0,0,0, 0,0,0,     0,0,1), "cmd_done");
    // hresp does not end a grant; htrans dropped during a stall waits for s_hready
    add(v(1,0,1,1, 0,0,0, 0,0,0,     0,0,1), "err_idle");
    add(v(1,0,1,1, 0,0,0, 0,1,0,     1,1,0), "err_stall");
    add(v(1,0,1,1, 0,0,0, 1,1,8'h81, 1,1,0), "err_beat");
    add(v(1,0,0,1, 0,0,0, 0,0,0,     1,1,0), "drop_stall");
    add(v(1,0,0,1, 0,0,0, 1,0,8'h82, 1,1,0), "drop_beat");
    add(v(0,0,0,0, 0,0,0, 0,0,0,     0,0,0), "drop_done");

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("%s[%0d]", tbl_tag[i], i));

    // asynchronous reset mid-burst in OWN1
    apply(v(0,0,0,0, 1,1,1, 1,0,0, 0,0,0), "rst_idle");
    apply(v(0,0,0,0, 1,1,1, 1,0,9, 2,1,1), "rst_b1");
    x = v(0,0,0,0, 1,1,1, 1,0,9, 0,0,1);
    drive(x);
    hreset_n = 1'b0;
    sb.push_back(expect_of(x));
    #2;
    compare("rst_mid");
    @(posedge hclk);
    #1;
    hreset_n = 1'b1;
    apply(v(1,0,1,0, 1,1,0, 1,0,0,     0,0,1), "rst_tie");
    apply(v(1,0,1,0, 1,1,0, 1,0,8'h44, 1,0,0), "rst_m0");
    apply(v(0,0,0,0, 0,0,0, 0,0,0,     0,0,0), "rst_done");

`ifdef FSB8_ARB_TIMEOUT_EN
    apply(v(1,0,1,0, 0,0,0, 0,0,0, 0,0,0), "tmo_idle");
    for (int i = 1; i < 8; i++) apply(v(1,0,1,0, 0,0,0, 0,0,0, 1,0,0), $sformatf("tmo_stall%0d", i));
    x = v(1,0,1,0, 0,0,0, 0,0,0, 1,0,0);
    e = expect_of(x);
    e.r0 = 1'b1; e.e0 = 1'b1; e.sel = 1'b0; e.tr = 1'b0;
    apply_exp(x, e, "tmo_fire");
    apply(v(0,0,0,0, 0,0,0, 0,0,0, 0,0,0), "tmo_idle_after");
`else
    e = '0;
    if (cap_bu[0] != 1'b1) $display("cap table corrupted");
`endif

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
